// File: rtl/core_sched_pkg.sv
// -----------------------------------------------------------------------------
// core_sched_pkg
//   Shared constants for the core scheduler: result line geometry, default
//   parameter values, FSM state encoding and a small index-width helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package core_sched_pkg;

  localparam int WORD_W               = 32;
  localparam int RES_WORDS            = 8;
  localparam int RES_W                = WORD_W * RES_WORDS;
  localparam int LEN_W                = 8;
  localparam int DEFAULT_NREQ         = 4;
  localparam int DEFAULT_BUSY_TIMEOUT = 15;

  // FSM state encoding, kept as plain constants for legacy tool flows.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ARB       = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_CAPTURE   = 3'd5;
  localparam logic [2:0] ST_WRITE     = 3'd6;
  localparam logic [2:0] ST_FINISH    = 3'd7;

  // Width of a requester index; never zero, even for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_scheduler_if.sv
// -----------------------------------------------------------------------------
// core_scheduler_if
//   Bundles the requester, collision-core and result-memory signals of the
//   core scheduler.
//   master : scheduler view (drives gnt, job_done, core_rst_n, wr_*, weout, err)
//   slave  : environment view (drives req, req_base, req_len, core_done,
//            res_data)
// -----------------------------------------------------------------------------
interface core_scheduler_if
  import core_sched_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ
);

  logic [NREQ-1:0]        req;
  logic [NREQ*WORD_W-1:0] req_base;
  logic [NREQ*LEN_W-1:0]  req_len;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        job_done;
  logic                   core_rst_n;
  logic                   core_done;
  logic [RES_W-1:0]       res_data;
  logic [WORD_W-1:0]      wr_addr;
  logic [RES_W-1:0]       wr_data;
  logic                   weout;
  logic                   err;

  modport master (
    input  req, req_base, req_len, core_done, res_data,
    output gnt, job_done, core_rst_n, wr_addr, wr_data, weout, err
  );

  modport slave (
    output req, req_base, req_len, core_done, res_data,
    input  gnt, job_done, core_rst_n, wr_addr, wr_data, weout, err
  );

endinterface

// File: rtl/core_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: searches the request vector starting at
//   the pointer position and wrapping, returns the first requester found.
//   i_req   : request vector
//   i_ptr   : index where the search starts
//   o_gnt   : one-hot grant (zero when no request)
//   o_idx   : index of the granted requester
//   o_valid : a requester was found
// -----------------------------------------------------------------------------
module rr_arbiter
  import core_sched_pkg::*;
#(
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin : search
    int               pos;
    logic [IDX_W-1:0] w_pos;
    // NOTE: every output and temporary gets a default before any branch,
    // otherwise paths that skip an assignment would infer latches.
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    pos     = 0;
    w_pos   = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = int'(i_ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      w_pos = IDX_W'(pos);
      if (!o_valid && i_req[w_pos]) begin
        o_valid      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// -----------------------------------------------------------------------------
// core_scheduler
//   Shares one collision core among NREQ requesters. A granted job runs the
//   core req_len times; each run's 256-bit result is written to
//   base + 8*k. Busy-start is supervised by a timeout that aborts the job and
//   sets a sticky error flag.
//   clk       : clock, rising edge
//   rstmaster : synchronous active-low reset
//   bus       : requester / core / result-memory signals (master view)
// -----------------------------------------------------------------------------
module core_scheduler
  import core_sched_pkg::*;
#(
  parameter int NREQ         = DEFAULT_NREQ,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic             clk,
  input  logic             rstmaster,
  core_scheduler_if.master bus
);

  localparam int                IDX_W   = idx_width(NREQ);
  localparam int                TO_W    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(NREQ - 1);

  logic [2:0]        r_state;
  logic [NREQ-1:0]   r_gnt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [WORD_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_k;
  logic [TO_W-1:0]   r_tmo;
  logic [WORD_W-1:0] r_wr_addr;
  logic [RES_W-1:0]  r_wr_data;
  logic              r_err;

  logic [NREQ-1:0]   w_arb_gnt;
  logic [IDX_W-1:0]  w_arb_idx;
  logic              w_arb_valid;
  logic [WORD_W-1:0] w_sel_base;
  logic [LEN_W-1:0]  w_sel_len;
  logic [LEN_W-1:0]  w_k_next;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req   (bus.req),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  // Slice of the winning requester's base and length.
  assign w_sel_base = WORD_W'(bus.req_base >> (int'(w_arb_idx) * WORD_W));
  assign w_sel_len  = LEN_W'(bus.req_len >> (int'(w_arb_idx) * LEN_W));
  assign w_k_next   = r_k + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (!rstmaster) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_idx     <= '0;
      r_rr_ptr  <= '0;
      r_base    <= '0;
      r_len     <= '0;
      r_k       <= '0;
      r_tmo     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|bus.req && bus.core_done) r_state <= ST_ARB;
        end
        ST_ARB: begin
          // A request that vanished between IDLE and ARB simply returns.
          if (w_arb_valid) begin
            r_gnt   <= w_arb_gnt;
            r_idx   <= w_arb_idx;
            r_base  <= w_sel_base;
            r_len   <= w_sel_len;
            r_k     <= '0;
            r_state <= (w_sel_len == '0) ? ST_FINISH : ST_START;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_START: begin
          r_tmo   <= '0;
          r_state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!bus.core_done) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_tmo == TO_LAST) begin
            r_err   <= 1'b1;
            r_state <= ST_FINISH;
          end else begin
            r_tmo <= r_tmo + TO_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (bus.core_done) r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_wr_data <= bus.res_data;
          r_wr_addr <= r_base + WORD_W'({r_k, 3'b000});
          r_state   <= ST_WRITE;
        end
        ST_WRITE: begin
          r_k     <= w_k_next;
          r_state <= (w_k_next < r_len) ? ST_START : ST_FINISH;
        end
        ST_FINISH: begin
          r_gnt    <= '0;
          r_rr_ptr <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Pulses are decoded from the registered state, so each lasts exactly the
  // one cycle spent in its state and all return to idle values on reset.
  assign bus.gnt        = r_gnt;
  assign bus.job_done   = (r_state == ST_FINISH) ? r_gnt : '0;
  assign bus.core_rst_n = (r_state != ST_START);
  assign bus.weout      = (r_state == ST_WRITE);
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_core_scheduler.sv
module tb_core_scheduler;
  import core_sched_pkg::*;

  localparam int N  = 4;
  localparam int BT = 15;

  logic clk = 1'b0;
  logic rstmaster;

  core_scheduler_if #(.NREQ(N)) bus();

  core_scheduler #(.NREQ(N), .BUSY_TIMEOUT(BT)) dut (
    .clk       (clk),
    .rstmaster (rstmaster),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Collision-core model controls and the results it has produced.
  int               core_lat  = 3;
  bit               core_hang = 1'b0;
  int               busy_cnt  = 0;
  logic [RES_W-1:0] res_q[$];

  logic [31:0] base_a[N];
  logic [7:0]  len_a[N];

  typedef struct {
    logic [3:0]  req;
    logic [31:0] base;
    logic [7:0]  len;
    int          lat;
    logic [3:0]  exp_gnt;
    int          exp_nwr;
    logic [31:0] exp_a0;
    logic [31:0] exp_a1;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [RES_W-1:0] act,
                       input logic [RES_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_cfg();
    bus.req_base = {base_a[3], base_a[2], base_a[1], base_a[0]};
    bus.req_len  = {len_a[3], len_a[2], len_a[1], len_a[0]};
  endtask

  function automatic logic [RES_W-1:0] rand_line();
    logic [RES_W-1:0] v;
    v = '0;
    for (int i = 0; i < RES_WORDS; i++) v = {v[RES_W-WORD_W-1:0], 32'($urandom())};
    return v;
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < N; i++) if (((v >> i) & 4'd1) != 4'd0) return i;
    return 0;
  endfunction

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    int j;
    for (int i = 0; i < N; i++) begin
      j = (p + i) % N;
      if (((r >> j) & 4'd1) != 4'd0) return j;
    end
    return 0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " gnt"},        bus.gnt, 0);
    check({tag, " job_done"},   bus.job_done, 0);
    check({tag, " core_rst_n"}, bus.core_rst_n, 1);
    check({tag, " weout"},      bus.weout, 0);
    check({tag, " wr_addr"},    bus.wr_addr, 0);
    check({tag, " wr_data"},    bus.wr_data, 0);
    check({tag, " err"},        bus.err, 0);
  endtask

  // Runs one job from grant to the cycle after job_done; every write is
  // checked against base+8k and the core result produced for that run.
  task automatic do_job(input string tag, input logic [3:0] exp_gnt,
                        input logic [31:0] exp_base, input int exp_len,
                        input bit drop, input bit clr_at_done,
                        output logic [31:0] a0, output logic [31:0] a1,
                        output int nwr);
    int          starts, gbad, obad, g;
    bit          seen, done;
    logic [31:0] ea;
    a0 = '0; a1 = '0; nwr = 0; starts = 0; gbad = 0; obad = 0;
    seen = 1'b0; done = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (bus.gnt != 4'd0) seen = 1'b1;
    end
    check({tag, " grant seen"}, seen, 1);
    if (!seen) return;
    check({tag, " gnt"}, bus.gnt, exp_gnt);
    if (!bus.core_rst_n) starts++;
    if (drop) begin
      g = onehot_idx(exp_gnt);
      bus.req[g] = 1'b0;
      base_a[g]  = $urandom();
      len_a[g]   = 8'($urandom_range(0, 255));
      apply_cfg();
    end
    for (int c = 0; c < 3000 && !done; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (!bus.core_rst_n) starts++;
      end
      if (bus.gnt !== exp_gnt) gbad++;
      if (bus.weout) begin
        ea = exp_base + 32'(8 * nwr);
        check({tag, " wr_addr"}, bus.wr_addr, ea);
        check({tag, " result available"}, res_q.size() > 0, 1);
        if (res_q.size() > 0) check({tag, " wr_data"}, bus.wr_data, res_q.pop_front());
        if (nwr == 0) a0 = bus.wr_addr;
        if (nwr == 1) a1 = bus.wr_addr;
        nwr++;
        if (bus.job_done != 4'd0) obad++;
      end
      if (bus.job_done != 4'd0) done = 1'b1;
    end
    check({tag, " done seen"}, done, 1);
    check({tag, " job_done"}, bus.job_done, exp_gnt);
    check({tag, " writes"}, nwr, exp_len);
    check({tag, " core starts"}, starts, exp_len);
    check({tag, " gnt held"}, gbad, 0);
    check({tag, " weout with job_done"}, obad, 0);
    if (clr_at_done) bus.req = '0;
    @(negedge clk);
    check({tag, " job_done one cycle"}, bus.job_done, 0);
    check({tag, " gnt released"}, bus.gnt, 0);
  endtask

  // Collision core: pulled low by a start pulse, busy for core_lat cycles,
  // then presents a fresh result and raises done.
  initial begin
    bus.core_done = 1'b1;
    bus.res_data  = '0;
    forever begin
      @(negedge clk);
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          bus.res_data  = rand_line();
          bus.core_done = 1'b1;
          res_q.push_back(bus.res_data);
        end
      end else if (!bus.core_rst_n && !core_hang) begin
        busy_cnt      = core_lat;
        bus.core_done = 1'b0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a0, a1;
    int          nwr, g, mptr, wbad;
    bit          seen;

    tbl[0] = '{req: 4'b0001, base: 32'h0000_0100, len: 8'd2, lat: 3,
               exp_gnt: 4'b0001, exp_nwr: 2, exp_a0: 32'h0000_0100, exp_a1: 32'h0000_0108};
    tbl[1] = '{req: 4'b0100, base: 32'h0000_0500, len: 8'd0, lat: 3,
               exp_gnt: 4'b0100, exp_nwr: 0, exp_a0: 32'h0, exp_a1: 32'h0};
    tbl[2] = '{req: 4'b1000, base: 32'hFFFF_FFF8, len: 8'd2, lat: 4,
               exp_gnt: 4'b1000, exp_nwr: 2, exp_a0: 32'hFFFF_FFF8, exp_a1: 32'h0000_0000};
    tbl[3] = '{req: 4'b0010, base: 32'h0000_0040, len: 8'd1, lat: 2,
               exp_gnt: 4'b0010, exp_nwr: 1, exp_a0: 32'h0000_0040, exp_a1: 32'h0};

    rstmaster = 1'b0;
    bus.req   = '0;
    for (int i = 0; i < N; i++) begin base_a[i] = '0; len_a[i] = '0; end
    apply_cfg();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstmaster = 1'b1;

    // All requesters, len 1: strict rotation 0,1,2,3,0.
    for (int i = 0; i < N; i++) begin
      base_a[i] = 32'h1000 * (i + 1);
      len_a[i]  = 8'd1;
    end
    apply_cfg();
    core_lat = 2;
    bus.req  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      do_job($sformatf("rot%0d", i), 4'(1 << (i % N)), base_a[i % N], 1,
             1'b0, i == 4, a0, a1, nwr);
    end

    // Directed single-job vectors.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) len_a[i] = '0;
      g         = onehot_idx(tbl[t].req);
      base_a[g] = tbl[t].base;
      len_a[g]  = tbl[t].len;
      apply_cfg();
      core_lat  = tbl[t].lat;
      bus.req   = tbl[t].req;
      do_job($sformatf("vec%0d", t), tbl[t].exp_gnt, tbl[t].base, tbl[t].exp_nwr,
             1'b1, 1'b1, a0, a1, nwr);
      if (nwr >= 1) check($sformatf("vec%0d addr0", t), a0, tbl[t].exp_a0);
      if (nwr >= 2) check($sformatf("vec%0d addr1", t), a1, tbl[t].exp_a1);
    end

    // Busy timeout: core never starts computing.
    core_hang = 1'b1;
    base_a[1] = 32'h800;
    len_a[1]  = 8'd1;
    apply_cfg();
    bus.req = 4'b0010;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (bus.gnt != 4'd0) seen = 1'b1;
    end
    check("timeout grant seen", seen, 1);
    check("timeout gnt", bus.gnt, 4'b0010);
    check("timeout start pulse", bus.core_rst_n, 0);
    wbad = 0;
    for (int c = 1; c <= BT + 1; c++) begin
      @(negedge clk);
      if (bus.weout) wbad++;
      if (c == BT) check("timeout err before limit", bus.err, 0);
    end
    check("timeout err", bus.err, 1);
    check("timeout job_done", bus.job_done, 4'b0010);
    check("timeout no weout", wbad, 0);
    bus.req   = '0;
    core_hang = 1'b0;
    repeat (5) @(negedge clk);
    check("timeout err sticky", bus.err, 1);
    check("timeout gnt cleared", bus.gnt, 0);

    // Reset while waiting on the core.
    base_a[2] = 32'h2000;
    len_a[2]  = 8'd3;
    apply_cfg();
    core_lat = 8;
    bus.req  = 4'b0100;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (bus.gnt != 4'd0) seen = 1'b1;
    end
    check("midrst grant seen", seen, 1);
    check("midrst gnt", bus.gnt, 4'b0100);
    repeat (3) @(negedge clk);
    rstmaster = 1'b0;
    bus.req   = '0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    rstmaster = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (bus.core_done) seen = 1'b1;
    end
    check("midrst core idle", seen, 1);
    res_q.delete();
    base_a[1] = 32'h3000; len_a[1] = 8'd1;
    base_a[3] = 32'h4000; len_a[3] = 8'd1;
    apply_cfg();
    core_lat = 3;
    bus.req  = 4'b1010;
    do_job("midrst rearb", 4'b0010, 32'h3000, 1, 1'b0, 1'b1, a0, a1, nwr);
    mptr = 2;

    // Randomized jobs against the round-robin / address reference model.
    for (int t = 0; t < 40; t++) begin
      logic [3:0] r;
      r = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        base_a[i] = $urandom();
        len_a[i]  = 8'($urandom_range(0, 3));
      end
      apply_cfg();
      core_lat = $urandom_range(2, 6);
      g        = rr_pick(r, mptr);
      bus.req  = r;
      do_job($sformatf("rand%0d", t), 4'(1 << g), base_a[g], int'(len_a[g]),
             1'($urandom_range(0, 1)), 1'b1, a0, a1, nwr);
      mptr = (g + 1) % N;
    end
    check("rand err clear", bus.err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
